// File: rtl/weight_update_nn.sv
// Sequential SGD weight-update engine: w <- w - lr*delta*a, one weight per cycle, signed Q(WIDTH-FRAC).FRAC.
// Define WEIGHT_UPDATE_SAT_EN to saturate every narrowing instead of two's-complement wrap.
module weight_update_nn #(
    parameter int N_IN   = 2,
    parameter int N_HL_P = 3,
    parameter int N_OUT  = 2,
    parameter int WIDTH  = 32,
    parameter int FRAC   = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [N_OUT*WIDTH-1:0]           i_dlto,
    input  logic [N_HL_P*WIDTH-1:0]          i_dlth,
    input  logic [N_HL_P*WIDTH-1:0]          i_hd_a,
    input  logic [N_IN*WIDTH-1:0]            i_in_a,
    input  logic [WIDTH-1:0]                 i_lr,
    input  logic [N_OUT*N_HL_P*WIDTH-1:0]    i_out_w,
    input  logic [N_HL_P*N_IN*WIDTH-1:0]     i_hd_w,
    output logic [N_OUT*N_HL_P*WIDTH-1:0]    o_out_w,
    output logic [N_HL_P*N_IN*WIDTH-1:0]     o_hd_w,
    output logic                             o_valid,
    input  logic                             i_rdy,
    output logic                             o_busy
);
    localparam int N_OW = N_OUT * N_HL_P;
    localparam int N_HW = N_HL_P * N_IN;
    localparam int KW   = $clog2(N_OW + N_HW + 1);
    localparam logic signed [2*WIDTH-1:0] MAX_V = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] MIN_V = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, UPD_OUT, UPD_HID, DONE} state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d, row_q, row_d, col_q, col_d;
    logic signed [WIDTH-1:0] dlto_q [N_OUT],  dlto_d [N_OUT];
    logic signed [WIDTH-1:0] dlth_q [N_HL_P], dlth_d [N_HL_P];
    logic signed [WIDTH-1:0] hd_a_q [N_HL_P], hd_a_d [N_HL_P];
    logic signed [WIDTH-1:0] in_a_q [N_IN],   in_a_d [N_IN];
    logic signed [WIDTH-1:0] out_w_q[N_OW],   out_w_d[N_OW];
    logic signed [WIDTH-1:0] hd_w_q [N_HW],   hd_w_d [N_HW];
    logic signed [WIDTH-1:0] lr_q, lr_d;
    logic                    ready_q, ready_d, valid_q, valid_d, busy_q, busy_d;

    logic signed [WIDTH-1:0]   delta_sel, act_sel, w_sel, p_val, q_val, w_new;
    logic signed [2*WIDTH-1:0] prod_da, prod_lp, diff_ext;
    logic signed [WIDTH:0]     diff;

    function automatic logic signed [WIDTH-1:0] narrow(input logic signed [2*WIDTH-1:0] v);
`ifdef WEIGHT_UPDATE_SAT_EN
        if (v > MAX_V)
            return MAX_V[WIDTH-1:0];
        else if (v < MIN_V)
            return MIN_V[WIDTH-1:0];
        else
            return v[WIDTH-1:0];
`else
        return v[WIDTH-1:0];
`endif
    endfunction

    // Operand selection for the shared datapath: row/col track k's quotient/remainder.
    always_comb begin
        delta_sel = '0;
        act_sel   = '0;
        w_sel     = '0;
        if (state_q == UPD_OUT) begin
            for (int j = 0; j < N_OUT; j++)  if (row_q == KW'(j)) delta_sel = dlto_q[j];
            for (int j = 0; j < N_HL_P; j++) if (col_q == KW'(j)) act_sel   = hd_a_q[j];
            for (int j = 0; j < N_OW; j++)   if (k_q == KW'(j))   w_sel     = out_w_q[j];
        end else if (state_q == UPD_HID) begin
            for (int j = 0; j < N_HL_P; j++) if (row_q == KW'(j)) delta_sel = dlth_q[j];
            for (int j = 0; j < N_IN; j++)   if (col_q == KW'(j)) act_sel   = in_a_q[j];
            for (int j = 0; j < N_HW; j++)   if (k_q == KW'(j))   w_sel     = hd_w_q[j];
        end
    end

    assign prod_da  = delta_sel * act_sel;
    assign p_val    = narrow(prod_da >>> FRAC);
    assign prod_lp  = lr_q * p_val;
    assign q_val    = narrow(prod_lp >>> FRAC);
    assign diff     = {w_sel[WIDTH-1], w_sel} - {q_val[WIDTH-1], q_val};
    assign diff_ext = {{(WIDTH-1){diff[WIDTH]}}, diff};
    assign w_new    = narrow(diff_ext);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        dlto_d  = dlto_q;
        dlth_d  = dlth_q;
        hd_a_d  = hd_a_q;
        in_a_d  = in_a_q;
        out_w_d = out_w_q;
        hd_w_d  = hd_w_q;
        lr_d    = lr_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    for (int j = 0; j < N_OUT; j++)  dlto_d[j]  = i_dlto[j*WIDTH +: WIDTH];
                    for (int j = 0; j < N_HL_P; j++) dlth_d[j]  = i_dlth[j*WIDTH +: WIDTH];
                    for (int j = 0; j < N_HL_P; j++) hd_a_d[j]  = i_hd_a[j*WIDTH +: WIDTH];
                    for (int j = 0; j < N_IN; j++)   in_a_d[j]  = i_in_a[j*WIDTH +: WIDTH];
                    for (int j = 0; j < N_OW; j++)   out_w_d[j] = i_out_w[j*WIDTH +: WIDTH];
                    for (int j = 0; j < N_HW; j++)   hd_w_d[j]  = i_hd_w[j*WIDTH +: WIDTH];
                    lr_d    = i_lr;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = UPD_OUT;
                end
            end
            UPD_OUT: begin
                for (int j = 0; j < N_OW; j++) if (k_q == KW'(j)) out_w_d[j] = w_new;
                k_d   = k_q + 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == KW'(N_HL_P - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end
                if (k_q == KW'(N_OW - 1)) begin
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = UPD_HID;
                end
            end
            UPD_HID: begin
                for (int j = 0; j < N_HW; j++) if (k_q == KW'(j)) hd_w_d[j] = w_new;
                k_d   = k_q + 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == KW'(N_IN - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end
                if (k_q == KW'(N_HW - 1)) begin
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
        busy_d  = (state_d == UPD_OUT) || (state_d == UPD_HID);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            lr_q    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int j = 0; j < N_OUT; j++)  dlto_q[j]  <= '0;
            for (int j = 0; j < N_HL_P; j++) dlth_q[j]  <= '0;
            for (int j = 0; j < N_HL_P; j++) hd_a_q[j]  <= '0;
            for (int j = 0; j < N_IN; j++)   in_a_q[j]  <= '0;
            for (int j = 0; j < N_OW; j++)   out_w_q[j] <= '0;
            for (int j = 0; j < N_HW; j++)   hd_w_q[j]  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lr_q    <= lr_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            dlto_q  <= dlto_d;
            dlth_q  <= dlth_d;
            hd_a_q  <= hd_a_d;
            in_a_q  <= in_a_d;
            out_w_q <= out_w_d;
            hd_w_q  <= hd_w_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;

    for (genvar gi = 0; gi < N_OW; gi++) begin : g_out_w
        assign o_out_w[gi*WIDTH +: WIDTH] = out_w_q[gi];
    end
    for (genvar gi = 0; gi < N_HW; gi++) begin : g_hd_w
        assign o_hd_w[gi*WIDTH +: WIDTH] = hd_w_q[gi];
    end
endmodule

// File: doc/weight_update_nn.md
# weight_update_nn

Sequential weight-update engine on the consumer side of the delta calculation stage (`delta_nn`). It accepts one training sample's deltas and activations and applies `w <- w - lr * delta * a` to every output-layer and hidden-layer weight. It uses one shared two-multiplier datapath and updates one weight per cycle. Updated weights are exported for the next forward pass; all values are signed Q8.24 (`0x01000000` = 1.0).

## Interface

**Parameters**
- `N_IN`, default 2: network inputs.
- `N_HL_P`, default 3: hidden perceptrons.
- `N_OUT`, default 2: output perceptrons.
- `WIDTH`, default 32: word width.
- `FRAC`, default 24: fractional bits.

**Ports**
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `i_valid`, in, 1: sample offered.
- `o_ready`, out, 1: engine idle, able to accept.
- `i_dlto`, in, N_OUT*WIDTH: output deltas; slice o.
- `i_dlth`, in, N_HL_P*WIDTH: hidden deltas; slice h.
- `i_hd_a`, in, N_HL_P*WIDTH: hidden activations; slice h.
- `i_in_a`, in, N_IN*WIDTH: network inputs; slice i.
- `i_lr`, in, WIDTH: learning rate.
- `i_out_w`, in, N_OUT*N_HL_P*WIDTH: output weights; slice (o*N_HL_P+h) is hidden h -> output o.
- `i_hd_w`, in, N_HL_P*N_IN*WIDTH: hidden weights; slice (h*N_IN+i) is input i -> hidden h.
- `o_out_w`, out, N_OUT*N_HL_P*WIDTH: working/updated output weights, same packing as `i_out_w`.
- `o_hd_w`, out, N_HL_P*N_IN*WIDTH: working/updated hidden weights, same packing as `i_hd_w`.
- `o_valid`, out, 1: update complete, outputs stable.
- `i_rdy`, in, 1: downstream takes result.
- `o_busy`, out, 1: update in progress.

## Operation

**States:** IDLE, UPD_OUT, UPD_HID, DONE.

**IDLE**
- `o_ready` = 1.
- On `i_valid & o_ready`, register all inputs (deltas, activations, lr, both weight sets) and clear index k.
- Go to UPD_OUT.

**UPD_OUT**
- Each cycle updates output weight k: o = k / N_HL_P, h = k % N_HL_P, using `i_dlto[o]` and `i_hd_a[h]`.
- After k = N_OUT*N_HL_P-1, clear k and go to UPD_HID.

**UPD_HID**
- Each cycle updates hidden weight k: h = k / N_IN, i = k % N_IN, using `i_dlth[h]` and `i_in_a[i]`.
- After the last weight, go to DONE.

**DONE**
- `o_valid` = 1; weights are held.
- On `i_rdy`, go to IDLE.

**Arithmetic** (per cycle, combinational, written at the edge):
- `p = (delta * a) >>> FRAC`, using the full 2*WIDTH product and an arithmetic shift (floor toward -inf).
- `q = (lr * p) >>> FRAC`.
- `w_new = w - q`.
- Narrowing to WIDTH follows the rule under Configuration.

**General rules**
- Latched inputs are used, so input changes after acceptance are ignored.
- `i_valid` while not in IDLE is ignored; no queueing.
- `o_busy` = 1 in UPD_OUT and UPD_HID.

## Timing

- **Reset:** an edge with `rst_n` = 0 forces:
  - state IDLE, k = 0;
  - `o_out_w`, `o_hd_w`, and all latched inputs = 0;
  - `o_valid` = 0, `o_busy` = 0, `o_ready` = 1.
- **Reset mid-operation:** the update is abandoned and the partial weights are zeroed; no `o_valid` is produced.
- **Latency:** with acceptance on edge E0, weight updates occur on E1 through E(N_OUT*N_HL_P + N_HL_P*N_IN). With defaults that is E1..E12. `o_valid` is high from the cycle after the last write (E12 with defaults), i.e. 12 cycles after acceptance.
- **Result hold:** `o_valid` stays high until an edge with `i_rdy` = 1. The next acceptance is possible one cycle later, so throughput is one sample per 14 cycles at defaults.
- **Visibility:** `o_out_w` and `o_hd_w` change one slice per edge during the update; values are final only while `o_valid` = 1.
- **`i_rdy` outside DONE:** ignored.

## Configuration

`WEIGHT_UPDATE_SAT_EN`:
- **Defined:** each narrowing of p, q, and `w_new` saturates to `0x7FFFFFFF` / `0x80000000` (for WIDTH = 32) when the value is out of range.
- **Undefined:** narrowing keeps the low WIDTH bits (two's-complement wrap).

## Test plan

- **Basic update:** lr = `0x01000000`, `i_dlto[0]` = `0x00800000`, `i_hd_a[0]` = `0x01000000`, `w(o0,h0)` = `0x01000000`; all other deltas 0 -> after `o_valid`, `o_out_w` slice 0 = `0x00800000`, all other weights unchanged.
- **Floor rounding:** `i_dlth[0]` = `0xFFFFFFFF`, `i_in_a[0]` = `0x00800000`, lr = `0x01000000`, `w(h0,i0)` = 0 -> `o_hd_w` slice 0 = `0x00000001`.
- **Overflow:** `w(o0,h0)` = `0x80000001`, delta = a = lr = `0x01000000` -> `0x7F000001` without the macro; `0x80000000` with `WEIGHT_UPDATE_SAT_EN`.
- **Latency and handshake:** accept at E0 with `i_rdy` held 0 -> `o_busy` high for 12 cycles, then `o_valid` high and held. Raising `i_rdy` for one edge -> `o_valid` low and `o_ready` high on the next cycle. A second `i_valid` during busy is ignored.
- **Reset mid-operation:** drive `rst_n` = 0 at E5 -> next cycle: all weights 0, `o_valid` 0, `o_ready` 1. After release, a new sample completes normally.
- **Delta_nn vectors:** lr = `0x00199999`, hidden activations `00ec7ffe_00f37fff_00d13ffd`, output activations `00a837e6_00b7f2bc`, target `00000000_01000000`, with deltas taken from `delta_nn` -> every weight matches a Q8.24 floor-rounded golden model bit-exactly.
